// File: rtl/morse_key_decoder.sv
// Hand-keyed Morse decoder: synchronises and debounces a raw key, times each
// press against a unit clock, and emits one 6-bit symbol index per letter.
module morse_key_decoder #(
    parameter int UNIT_CYCLES     = 5_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       key_n,
    output logic       key_pressed,
    output logic [5:0] morse_code,
    output logic       code_valid,
    output logic       busy
);

    localparam int PW = $clog2(UNIT_CYCLES);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [PW-1:0] PRE_LAST = PW'(UNIT_CYCLES - 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [5:0] CODE_BLANK = 6'd36;
    localparam logic [5:0] CODE_ERR   = 6'd63;

    typedef enum logic [1:0] {S_IDLE, S_MARK, S_SPACE} state_t;

    logic          r_sync1, r_sync2, r_key;
    logic [DW-1:0] r_deb_cnt;
    logic [PW-1:0] r_pre;
    logic [3:0]    r_units;
    state_t        r_state;
    logic [5:0]    r_pattern;
    logic [2:0]    r_count;
    logic          r_ovf;
    logic [5:0]    r_code;
    logic          r_valid;
    logic          r_busy;

    logic       w_flip, w_rise, w_fall, w_tick, w_dash, w_gap;
    logic [3:0] w_units_adv;
    logic       w_unused_pat_msb;

    // Standard International Morse; the first element sits at bit cnt-1.
    function automatic logic [5:0] f_decode(input logic [2:0] cnt,
                                            input logic [4:0] pat,
                                            input logic       ovf);
        logic [5:0] code;
        code = CODE_ERR;
        if (!ovf) begin
            case (cnt)
                3'd1: code = pat[0] ? 6'd29 : 6'd14;
                3'd2: begin
                    case (pat[1:0])
                        2'b00:   code = 6'd18;
                        2'b01:   code = 6'd10;
                        2'b10:   code = 6'd23;
                        default: code = 6'd22;
                    endcase
                end
                3'd3: begin
                    case (pat[2:0])
                        3'b000:  code = 6'd28;
                        3'b001:  code = 6'd30;
                        3'b010:  code = 6'd27;
                        3'b011:  code = 6'd32;
                        3'b100:  code = 6'd13;
                        3'b101:  code = 6'd20;
                        3'b110:  code = 6'd16;
                        default: code = 6'd24;
                    endcase
                end
                3'd4: begin
                    case (pat[3:0])
                        4'b0000: code = 6'd17;
                        4'b0001: code = 6'd31;
                        4'b0010: code = 6'd15;
                        4'b0100: code = 6'd21;
                        4'b0110: code = 6'd25;
                        4'b0111: code = 6'd19;
                        4'b1000: code = 6'd11;
                        4'b1001: code = 6'd33;
                        4'b1010: code = 6'd12;
                        4'b1011: code = 6'd34;
                        4'b1100: code = 6'd35;
                        4'b1101: code = 6'd26;
                        default: code = CODE_ERR;
                    endcase
                end
                3'd5: begin
                    case (pat)
                        5'b11111: code = 6'd0;
                        5'b01111: code = 6'd1;
                        5'b00111: code = 6'd2;
                        5'b00011: code = 6'd3;
                        5'b00001: code = 6'd4;
                        5'b00000: code = 6'd5;
                        5'b10000: code = 6'd6;
                        5'b11000: code = 6'd7;
                        5'b11100: code = 6'd8;
                        5'b11110: code = 6'd9;
                        default:  code = CODE_ERR;
                    endcase
                end
                default: code = CODE_ERR;
            endcase
        end
        return code;
    endfunction

    assign w_flip = (r_sync2 != r_key) && (r_deb_cnt == DEB_LAST);
    assign w_rise = w_flip && !r_key;
    assign w_fall = w_flip && r_key;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_key     <= 1'b0;
            r_deb_cnt <= '0;
        end else begin
            r_sync1 <= ~key_n;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_key) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DEB_LAST) begin
                r_deb_cnt <= '0;
                r_key     <= ~r_key;
            end else begin
                r_deb_cnt <= r_deb_cnt + DW'(1);
            end
        end
    end

    // Unit value as of this edge; classification and gap detection use it so
    // that a press of exactly 2 units is a dash and the gap ends at R+3 units.
    assign w_tick = (r_pre == PRE_LAST);
    always_comb begin
        w_units_adv = r_units;
        if (w_tick && r_units != 4'd15) begin
            w_units_adv = r_units + 4'd1;
        end
    end
    assign w_dash = (w_units_adv >= 4'd2);
    assign w_gap  = (w_units_adv == 4'd3);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pre   <= '0;
            r_units <= '0;
        end else if (w_flip) begin
            r_pre   <= '0;
            r_units <= '0;
        end else begin
            r_pre   <= w_tick ? '0 : r_pre + PW'(1);
            r_units <= w_units_adv;
        end
    end

    // A press landing on the decode edge is picked up from IDLE via the level.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_pattern <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_code    <= CODE_BLANK;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_key || w_rise) begin
                        r_state <= S_MARK;
                        r_busy  <= 1'b1;
                    end
                end
                S_MARK: begin
                    if (w_fall) begin
                        if (r_count < 3'd6) begin
                            r_pattern <= {r_pattern[4:0], w_dash};
                            r_count   <= r_count + 3'd1;
                        end else begin
                            r_ovf <= 1'b1;
                        end
                        r_state <= S_SPACE;
                    end
                end
                S_SPACE: begin
                    if (w_gap) begin
                        r_code    <= f_decode(r_count, r_pattern[4:0], r_ovf);
                        r_valid   <= 1'b1;
                        r_pattern <= '0;
                        r_count   <= '0;
                        r_ovf     <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else if (w_rise) begin
                        r_state <= S_MARK;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign w_unused_pat_msb = r_pattern[5];

    assign key_pressed = r_key;
    assign morse_code  = r_code;
    assign code_valid  = r_valid;
    assign busy        = r_busy;

endmodule

// File: tb/tb_morse_key_decoder.sv
// Table-driven bench for morse_key_decoder with a scoreboard of expected symbols
// and the cycle on which each code_valid pulse is due.
module tb_morse_key_decoder;

    localparam int U   = 10;
    localparam int D   = 4;
    localparam int GAP = 12;
    localparam int LAT = 2 + D + 3 * U;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       key_n;
    logic       key_pressed;
    logic [5:0] morse_code;
    logic       code_valid;
    logic       busy;

    morse_key_decoder #(.UNIT_CYCLES(U), .DEBOUNCE_CYCLES(D)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .key_n       (key_n),
        .key_pressed (key_pressed),
        .morse_code  (morse_code),
        .code_valid  (code_valid),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [5:0] code;
        int         due;
    } exp_t;

    typedef struct {
        int         n;
        logic [6:0] pat;
        int         dot_len;
        int         dash_len;
        logic [5:0] exp_code;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[13];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic prev_valid = 1'b0;

    task automatic chk(input string name, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp_v);
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (code_valid) begin
            chk("back_to_back_valid", int'(prev_valid), 0);
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pulse at cycle %0d: got code %0d, expected no pulse", cyc, morse_code);
            end else begin
                e = sb.pop_front();
                chk("morse_code", int'(morse_code), int'(e.code));
                chk("pulse_cycle", cyc, e.due);
            end
        end
        prev_valid = code_valid;
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
            cyc++;
            monitor();
        end
    endtask

    task automatic apply_symbol(input vec_t v);
        exp_t e;
        for (int i = 0; i < v.n; i++) begin
            key_n = 1'b0;
            tick(v.pat[v.n-1-i] ? v.dash_len : v.dot_len);
            key_n = 1'b1;
            if (i == v.n - 1) begin
                e.code = v.exp_code;
                e.due  = cyc + LAT;
                sb.push_back(e);
            end else begin
                tick(GAP);
            end
        end
    endtask

    initial begin
        vecs[0]  = '{2, 7'b0000001, 10, 25, 6'd10};
        vecs[1]  = '{4, 7'b0001010, 10, 25, 6'd12};
        vecs[2]  = '{5, 7'b0011111, 10, 25, 6'd0};
        vecs[3]  = '{5, 7'b0000000, 10, 25, 6'd5};
        vecs[4]  = '{5, 7'b0011110, 10, 25, 6'd9};
        vecs[5]  = '{4, 7'b0001101, 10, 25, 6'd26};
        vecs[6]  = '{3, 7'b0000101, 10, 25, 6'd20};
        vecs[7]  = '{1, 7'b0000000, 19, 25, 6'd14};
        vecs[8]  = '{1, 7'b0000001, 10, 20, 6'd29};
        vecs[9]  = '{4, 7'b0000011, 10, 25, 6'd63};
        vecs[10] = '{7, 7'b0000000, 10, 25, 6'd63};
        vecs[11] = '{6, 7'b0000000, 10, 25, 6'd63};
        vecs[12] = '{1, 7'b0000001, 10, 25, 6'd29};

        // Reset held with a toggling key
        reset_n = 1'b0;
        key_n   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            key_n = ~key_n;
            chk("rst_key_pressed", int'(key_pressed), 0);
            chk("rst_morse_code", int'(morse_code), 36);
            chk("rst_code_valid", int'(code_valid), 0);
            chk("rst_busy", int'(busy), 0);
        end
        key_n = 1'b1;
        tick(3);
        reset_n = 1'b1;
        tick(20);
        chk("post_rst_code", int'(morse_code), 36);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_key", int'(key_pressed), 0);

        // Single 12-cycle dot with debounce latency checks
        key_n = 1'b0;
        tick(5);
        chk("kp_rise_early", int'(key_pressed), 0);
        tick(1);
        chk("kp_rise", int'(key_pressed), 1);
        chk("busy_rise", int'(busy), 1);
        tick(6);
        key_n = 1'b1;
        sb.push_back('{6'd14, cyc + LAT});
        tick(5);
        chk("kp_fall_early", int'(key_pressed), 1);
        tick(1);
        chk("kp_fall", int'(key_pressed), 0);
        tick(45);
        chk("e_busy_done", int'(busy), 0);
        chk("e_sb_drained", sb.size(), 0);

        foreach (vecs[j]) begin
            apply_symbol(vecs[j]);
            tick(10);
            chk("vec_busy_space", int'(busy), 1);
            tick(40);
            chk("vec_busy_done", int'(busy), 0);
            chk("vec_sb_drained", sb.size(), 0);
            chk("vec_code_held", int'(morse_code), int'(vecs[j].exp_code));
        end

        // Short glitches must never reach the debounced level
        for (int g = 0; g < 4; g++) begin
            key_n = 1'b0;
            tick(3);
            key_n = 1'b1;
            tick(6);
            chk("glitch_key", int'(key_pressed), 0);
        end
        tick(40);
        chk("glitch_busy", int'(busy), 0);

        // Reset during the letter gap of a three-element symbol
        for (int i = 0; i < 3; i++) begin
            key_n = 1'b0;
            tick(10);
            key_n = 1'b1;
            tick(GAP);
        end
        chk("abort_busy_before", int'(busy), 1);
        reset_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_code", int'(morse_code), 36);
        tick(2);
        reset_n = 1'b1;
        tick(50);
        chk("abort_code_after", int'(morse_code), 36);
        chk("abort_busy_after", int'(busy), 0);
        chk("final_sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/morse_key_decoder.md
# morse_key_decoder

Converts a single hand-keyed Morse pushbutton into symbol indices for the 7-segment Morse display stage, directly upstream of it. It synchronises and debounces the raw key, then classifies each press as dot or dash by duration. It collects up to six elements and, after a letter gap, emits one 6-bit symbol index: 0–9 digits, 10–35 letters A–Z, 36 blank, 63 error. That index drives the display's code input.

## Interface
- UNIT_CYCLES, 5_000_000, clock cycles per Morse time unit (100 ms at 50 MHz); minimum 4.
- DEBOUNCE_CYCLES, 500_000, consecutive stable cycles required to accept a key level change; minimum 2.
- clock  input  1  system clock; all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- key_n  input  1  raw pushbutton, active-low, asynchronous to clock, may bounce.
- key_pressed  output  1  debounced key level, 1 = pressed.
- morse_code  output  6  last decoded symbol index; held until next decode.
- code_valid  output  1  one-cycle pulse when morse_code updates.
- busy  output  1  high while a symbol is being collected (state ≠ IDLE).

## Operation
- Reset values: key_pressed=0, morse_code=36 (display blank), code_valid=0, busy=0, state IDLE, all counters and pattern cleared.
- Input path:
  - Two-flop synchroniser on key_n, then a debounce counter.
  - key_pressed changes only after the synchronised level differs from key_pressed for DEBOUNCE_CYCLES consecutive cycles.
  - Any return to the current level clears the debounce counter.
- Timing base:
  - A prescaler counts 0..UNIT_CYCLES-1. Each wrap increments a 4-bit unit counter, which saturates at 15.
  - Both counters clear on every debounced edge.
- Pattern store: 6-bit shift register plus 3-bit element count. Each element shifts in at the LSB (dot=0, dash=1).
- State machine:
  - IDLE: on debounced press → MARK.
  - MARK: on debounced release, classify the element: units<2 → dot, units≥2 → dash (saturated durations remain dash).
    - If count<6, append the element and increment count. If count=6, set the overflow flag instead.
    - Then → SPACE.
  - SPACE: a debounced press before units reaches 3 → MARK; the symbol continues.
  - SPACE: when units reaches 3 → decode, pulse code_valid, clear pattern/count/overflow → IDLE.
- Decode uses standard International Morse, combinational on (count, pattern), registered into morse_code:
  - Digits 0–9 → 0–9 (five elements each).
  - A–Z → 10–35 (1–4 elements).
  - Any other combination, overflow set, or count=6 → 63.
- Example encodings: E (count 1, pattern 0) → 14; C (count 4, pattern 1010) → 12; 0 (count 5, pattern 11111) → 0.
- Reset asserted mid-symbol discards the partial symbol immediately; no code_valid follows.

## Timing
- Input latency: a clean key_n edge reaches key_pressed 2 (sync) + DEBOUNCE_CYCLES cycles later.
- Release edge timing: a press whose debounced duration is P cycles counts as dot iff P < 2·UNIT_CYCLES.
- Letter gap: let the debounced release occur at edge R.
  - If no press follows, code_valid is high for exactly the cycle after edge R+3·UNIT_CYCLES, with morse_code updated on the same edge.
  - busy falls on that same edge.
- A press at exactly the edge where units reaches 3 loses to decode. It starts a new symbol from IDLE on the next cycle.
- code_valid never asserts on two consecutive cycles. morse_code is stable between pulses.
- No back-pressure: downstream samples morse_code at any time.

## Test plan
Bench parameters: UNIT_CYCLES=10, DEBOUNCE_CYCLES=4, clean key_n unless noted.

1. Reset: hold reset_n=0 with key_n toggling → morse_code=36, code_valid=0, key_pressed=0, busy=0 throughout. Release reset → outputs unchanged until a symbol completes.
2. Single dot: key_n low for 12 cycles, then high → key_pressed high 6 cycles after the fall. Exactly one code_valid 30 cycles after the debounced release, with morse_code=14 (E).
3. Sequences:
   - Dash(25)-dot(10)-dash(25)-dot(10), 12-cycle element gaps → one pulse, morse_code=12 (C).
   - Five 25-cycle dashes → 0.
   - Five dots → 5.
   - A 19-cycle press counts as dot; a 20-cycle press counts as dash.
4. Errors:
   - Pattern dot-dot-dash-dash → 63.
   - Seven dots → 63.
   - The next valid symbol decodes normally: a single dash → 29 (T).
5. Bounce and abort:
   - 3-cycle low glitches on key_n → no key_pressed change, no code_valid.
   - Reset asserted during the SPACE state of a 3-element symbol → no pulse afterward, morse_code=36.
